// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall encodings, stall-vector stage indices,
// the canonical NOP payload and the default bubble keep-masks per boundary.
package pipe_pkg;

    // Stall vector encoding: 1 stops the stage.
    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    // Stall-vector bit positions; bit 0 belongs to the PC.
    localparam int unsigned IF  = 1;
    localparam int unsigned ID  = 2;
    localparam int unsigned EX  = 3;
    localparam int unsigned MEM = 4;
    localparam int unsigned WB  = 5;

    // NOP building blocks.
    localparam logic [7:0]  EXE_NOP_OP   = 8'h00;
    localparam logic [4:0]  NOP_REG_ADDR = 5'h00;
    localparam logic [31:0] ZEROWORD     = 32'h0000_0000;

    // 64-bit NOP bundle: {pad, alu op, dest reg, data word}.
    localparam logic [63:0] NOP_PAYLOAD_64 = {19'h0, EXE_NOP_OP, NOP_REG_ADDR, ZEROWORD};

    // Default keep-masks. EX->MEM keeps the cp0 write fields (we, addr) across
    // a bubble so a pending cp0 write is not lost.
    localparam logic [63:0] KEEP_MASK_IF_ID  = 64'h0;
    localparam logic [63:0] KEEP_MASK_ID_EX  = 64'h0;
    localparam logic [63:0] KEEP_MASK_EX_MEM = 64'hFC00_0000_0000_0000;
    localparam logic [63:0] KEEP_MASK_MEM_WB = 64'h0;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; reset and clear both zero it.
module pipe_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear beats increment; stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/bubble/flush handling, a valid bit,
// per-bit bubble retention and multicycle scratch hand-back.
// Optional bubble/hold perf counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned          PAYLOAD_W        = 64,
    parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD      = '0,
    parameter logic [PAYLOAD_W-1:0] BUBBLE_KEEP_MASK = '0,
    parameter int unsigned          SCRATCH_W        = 64,
    parameter int unsigned          CNT_W            = 2,
    parameter int unsigned          STALL_W          = 6,
    parameter int unsigned          STAGE_IDX        = 3,
    parameter int unsigned          PERF_W           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_W-1:0]   stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [SCRATCH_W-1:0] in_scratch,
    input  logic [CNT_W-1:0]     in_cnt,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [SCRATCH_W-1:0] out_scratch,
    output logic [CNT_W-1:0]     out_cnt,
    input  logic                 perf_clr,
    output logic [PERF_W-1:0]    bubble_cnt,
    output logic [PERF_W-1:0]    hold_cnt
);

    if (STAGE_IDX + 1 >= STALL_W) begin : g_bad_stage_idx
        $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_stage_reg: CNT_W must be at least 1");
    end

    logic up;
    logic dn;
    logic is_bubble;
    logic is_hold;

    logic                 valid_q,   valid_d;
    logic [PAYLOAD_W-1:0] payload_q, payload_d;
    logic [SCRATCH_W-1:0] scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;

    assign up = (stall[STAGE_IDX] == STOP);
    assign dn = (stall[STAGE_IDX+1] == STOP);

    // Flush overrides any stall pattern, so it also suppresses perf events.
    assign is_bubble = !flush && up && !dn;
    assign is_hold   = !flush && up && dn;

    // Next-state decode: flush, advance, bubble, hold.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        scratch_d = in_scratch;
        cnt_d     = in_cnt;
        if (flush) begin
            valid_d   = 1'b0;
            payload_d = NOP_PAYLOAD;
            scratch_d = '0;
            cnt_d     = '0;
        end else if (!up) begin
            valid_d   = in_valid;
            payload_d = in_payload;
            scratch_d = '0;
            cnt_d     = '0;
        end else if (!dn) begin
            // Bubble: masked bits survive, the rest become NOP.
            valid_d   = 1'b0;
            payload_d = (payload_q & BUBBLE_KEEP_MASK) | (NOP_PAYLOAD & ~BUBBLE_KEEP_MASK);
        end
    end

    // Stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= NOP_PAYLOAD;
            scratch_q <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_payload = payload_q;
    assign out_scratch = scratch_q;
    assign out_cnt     = cnt_q;

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_cnt #(
        .W (PERF_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (is_bubble),
        .count (bubble_cnt)
    );

    pipe_sat_cnt #(
        .W (PERF_W)
    ) u_hold_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (is_hold),
        .count (hold_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf = perf_clr ^ is_bubble ^ is_hold;
    assign bubble_cnt  = '0;
    assign hold_cnt    = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage core.
- Generalises the per-stage latch, e.g. EX→MEM, in four ways:
  - configurable payload width;
  - stall-vector position;
  - per-bit bubble-retention mask;
  - multicycle scratch state (hi/lo accumulator and step count).
- Adds flush (exception) handling and a valid bit.
- Instantiated once per stage boundary. The stall vector comes from the central stall controller; flush comes from the exception unit.

Parameters:
- PAYLOAD_W, 64: width of the forwarded control/data bundle.
- NOP_PAYLOAD, 0: value loaded into the payload on bubble, flush or reset.
- BUBBLE_KEEP_MASK, 0: payload bits set to 1 keep their old value on a bubble; bits at 0 load NOP_PAYLOAD.
- SCRATCH_W, 64: width of the multicycle scratch field (hi/lo pair).
- CNT_W, 2: width of the multicycle step counter.
- STALL_W, 6: stall vector width.
- STAGE_IDX, 3: stall bit of the upstream stage. STAGE_IDX+1 is the downstream bit and must be less than STALL_W.
- PERF_W, 16: perf counter width (feature only).

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- stall, in, STALL_W: 1 = stage stopped.
- flush, in, 1: kill the stage contents.
- in_valid, in, 1: upstream slot holds a real instruction.
- in_payload, in, PAYLOAD_W: upstream bundle.
- in_scratch, in, SCRATCH_W: multicycle partial result from upstream.
- in_cnt, in, CNT_W: multicycle step count from upstream.
- out_valid, out, 1: registered valid.
- out_payload, out, PAYLOAD_W: registered bundle.
- out_scratch, out, SCRATCH_W: scratch state returned to upstream.
- out_cnt, out, CNT_W: step count returned to upstream.
- perf_clr, in, 1: clear perf counters (feature only).
- bubble_cnt, out, PERF_W: bubble cycles (feature only).
- hold_cnt, out, PERF_W: hold cycles (feature only).

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst; clock port clk. All outputs are registered, latency 1 cycle.
- Let up = stall[STAGE_IDX] and dn = stall[STAGE_IDX+1].
- Priority per rising edge, exactly one case applies:
  1. rst: out_valid=0, out_payload=NOP_PAYLOAD, out_scratch=0, out_cnt=0, perf counters=0.
  2. flush: same register values as reset, except the perf counters are untouched. flush wins over any stall combination.
  3. BUBBLE (up=1, dn=0):
     - out_valid=0.
     - out_payload = (out_payload & BUBBLE_KEEP_MASK) | (NOP_PAYLOAD & ~BUBBLE_KEEP_MASK).
     - out_scratch=in_scratch, out_cnt=in_cnt, so the multicycle op keeps its partial state.
  4. ADVANCE (up=0): out_valid=in_valid, out_payload=in_payload, out_scratch=0, out_cnt=0. The dn value is irrelevant here.
  5. HOLD (up=1, dn=1): out_valid and out_payload unchanged; out_scratch=in_scratch, out_cnt=in_cnt.
- in_valid=0 during ADVANCE still loads in_payload unchanged. Downstream qualifies on out_valid.
- There is no internal FSM beyond the implicit case decode. The block is combinationally transparent to nothing: no input-to-output path without a register.
- Elaboration error if STAGE_IDX+1 >= STALL_W or CNT_W < 1.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- With the macro defined:
  - bubble_cnt +1 on every BUBBLE cycle; hold_cnt +1 on every HOLD cycle.
  - Both counters saturate at all-ones.
  - perf_clr (synchronous) zeroes both and has priority over increment in the same cycle.
  - rst zeroes both; flush does not affect them.
- Without the macro: perf_clr is ignored, bubble_cnt and hold_cnt are tied to 0, and no counter flops exist.

Decomposition:
- Shared package pipe_pkg holds:
  - stall encodings STOP/NOT_STOP;
  - the stage index constants IF/ID/EX/MEM/WB;
  - the NOP payload constant built from EXE_NOP_OP, NOP_REG_ADDR and ZEROWORD;
  - the default keep-masks per boundary (EX→MEM keeps the cp0 write fields).
- One natural sub-module, pipe_sat_cnt: saturating counter with clear, instantiated twice under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, in_payload=0xDEAD, stall=0 → out_valid=0, out_payload=NOP_PAYLOAD, out_scratch=0, out_cnt=0, counters 0.
- Advance: stall=6'b000000, in_valid=1, in_payload=0x1234, in_scratch=0xFF → next cycle out_payload=0x1234, out_valid=1, out_scratch=0.
- Bubble with keep mask (BUBBLE_KEEP_MASK=0xF0, prior out_payload=0xA5):
  - Stimulus: stall=6'b001000 (STAGE_IDX=3), in_scratch=0x77, in_cnt=2'b01.
  - Expect: out_payload=0xA0, out_valid=0, out_scratch=0x77, out_cnt=1, bubble_cnt=1.
- Hold: stall=6'b011000 for 3 cycles, in_scratch changing 1,2,3 → out_payload frozen, out_scratch tracks 1,2,3, hold_cnt=3.
- Flush vs stall: flush=1 with stall=6'b011000 and out_payload=0x55 → out_valid=0, out_payload=NOP_PAYLOAD, out_scratch=0, counters unchanged.
- Saturation/clear (PERF_W=4):
  - Bubble 20 cycles → bubble_cnt=15.
  - perf_clr=1 together with a bubble → bubble_cnt=0.
